mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between instruction fetch (IF requester) and the MEM-stage load/store port (DM requester) of the 5-stage pipeline.
- Sequences every access as a registered request/acknowledge transaction on the memory side.
- Returns read data and a one-cycle ready pulse to the winning requester.
- Drives a combinational pipeline stall so that PC, IF_ID and the later pipeline registers freeze while an access is outstanding.

Parameters:
- ADDR_W, 32, address width of both requesters and the memory port.
- DATA_W, 32, data width.
- TIMEOUT, 64, maximum cycles in ISSUE waiting for mem_ack_i before the access is aborted; must be ≥2.
- ERR_DATA, 32'hDEADBEEF, read data returned on a timed-out access.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- if_req_i  in  1  fetch request; held with stable address until if_ready_o.
- if_addr_i  in  ADDR_W  fetch address (PC).
- if_rdata_o  out  DATA_W  fetched instruction; valid while if_ready_o=1.
- if_ready_o  out  1  one-cycle completion pulse for fetch.
- dm_req_i  in  1  data request; held with stable address, we and wdata until dm_ready_o.
- dm_we_i  in  1  1 = store, 0 = load.
- dm_addr_i  in  ADDR_W  data address (EX_MEM ALU result).
- dm_wdata_i  in  DATA_W  store data.
- dm_rdata_o  out  DATA_W  load data; valid while dm_ready_o=1.
- dm_ready_o  out  1  one-cycle completion pulse for data.
- mem_req_o  out  1  memory request, registered.
- mem_we_o  out  1  memory write enable, registered.
- mem_addr_o  out  ADDR_W  memory address, registered.
- mem_wdata_o  out  DATA_W  memory write data, registered.
- mem_rdata_i  in  DATA_W  memory read data; sampled on the cycle mem_ack_i=1.
- mem_ack_i  in  1  memory completion.
- stall_o  out  1  pipeline stall, combinational.
- err_o  out  1  sticky timeout flag.

Behaviour:
- Reset values: all outputs 0, state IDLE, last-grant = IF, timeout counter 0. During reset mem_req_o drops immediately (asynchronous); any in-flight access is abandoned and no ready pulse is issued.
- FSM states: IDLE, ISSUE, RESP.
  - IDLE: if any request is pending, choose a winner, latch its address, we and wdata into the mem_* registers, then go to ISSUE. mem_req_o=1 from the next cycle. An IF winner always has mem_we_o=0.
  - ISSUE: hold mem_req_o and all mem_* outputs stable.
    - On mem_ack_i: capture mem_rdata_i (0 for stores) into the winner's rdata register, drop mem_req_o, go to RESP.
    - If the timeout counter reaches TIMEOUT-1 without mem_ack_i: capture ERR_DATA, set err_o, drop mem_req_o, go to RESP.
  - RESP: pulse the winner's ready for exactly one cycle, then go to IDLE. No new grant is made in RESP, because the requester still shows its old request that cycle.
- Minimum latency with ack on the first ISSUE cycle: request seen in IDLE at cycle 0, mem_req_o high in cycle 1, ready in cycle 2, IDLE in cycle 3.
- Arbitration when both requesters are pending in IDLE:
  - DM wins, unless last-grant = DM, in which case IF wins. This alternates under continuous contention and starves neither requester.
  - A single requester always wins.
  - last-grant updates on each grant.
- Fetch flush: if if_req_i is low on the RESP cycle of an IF access, if_ready_o is suppressed and the data discarded. The memory transaction itself always completes.
- DM accesses are never aborted by the requester. dm_req_i dropping mid-transaction is a protocol violation; ready is still pulsed.
- rdata outputs hold their last value outside ready pulses.
- stall_o = (if_req_i & ~if_ready_o) | (dm_req_i & ~dm_ready_o).
- err_o stays set until rst_i.
- The timeout counter clears on entry to ISSUE and is held at 0 outside ISSUE.
- mem_ack_i outside ISSUE is ignored.

Decomposition:
- Shared package: FSM state encoding (IDLE/ISSUE/RESP), grant-owner enum (GNT_IF/GNT_DM), ERR_DATA default constant.
- One sub-module, mem_port_timeout, is natural: the timeout counter.
  - Inputs: clear, enable. Output: expired.
  - Width is clog2(TIMEOUT).

Test Plan:
- Lone IF request, addr=0x0000_0010, memory acks on first ISSUE cycle with 0x2001_0005 -> mem_req_o at cycle 1 with mem_we_o=0, if_ready_o=1 and if_rdata_o=0x2001_0005 at cycle 2, stall_o low from cycle 2.
- Both requesters pending, DM store addr=0x20 wdata=0x0000_00AA -> DM granted first (mem_we_o=1, mem_wdata_o=0xAA), dm_ready_o. IF is granted next; a second DM load waiting behind it is served after the IF access.
- Memory ack delayed 5 cycles -> mem_* stable for 5 ISSUE cycles, stall_o=1 throughout, single ready pulse 1 cycle after ack.
- No ack with TIMEOUT=8 -> after 8 ISSUE cycles mem_req_o drops, dm_rdata_o=0xDEADBEEF with dm_ready_o, err_o=1 and stays 1 until rst_i.
- IF request dropped during ISSUE (flush) -> memory still acked, if_ready_o never pulses, next IF request at new addr 0x40 is served normally.
- rst_i asserted mid-ISSUE -> mem_req_o, stall_o, err_o and the ready outputs go 0 asynchronously; after release, a new request completes with normal latency.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified-memory port arbiter: FSM states, grant owner
// and the default data word returned on an aborted access.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_DM = 1'b1
  } gnt_t;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

endpackage

// File: rtl/mem_port_timeout.sv
// Counts cycles spent waiting for the memory acknowledge; expired_o flags the
// last permitted waiting cycle so the owner can abort on that same edge.
module mem_port_timeout #(
  parameter int TIMEOUT = 64
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (enable_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // The owner leaves the waiting state when this fires, so the counter never wraps.
  assign expired_o = enable_i && (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction fetch and data load/store onto one single-ported
// memory, one registered request/acknowledge transaction at a time.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int                 ADDR_W   = 32,
  parameter int                 DATA_W   = 32,
  parameter int                 TIMEOUT  = 64,
  parameter logic [DATA_W-1:0]  ERR_DATA = DATA_W'(ERR_DATA_DEFAULT)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_ready_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              dm_ready_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i,
  output logic              stall_o,
  output logic              err_o
);

  state_t            state_q, state_d;
  gnt_t              owner_q, last_gnt_q;
  logic              grant, dm_win, done, timed_out, expired;
  logic              mem_req_q, mem_we_q, err_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q, resp_q, if_hold_q, dm_hold_q;

  mem_port_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear_i   (state_d != ST_ISSUE),
    .enable_i  (state_q == ST_ISSUE),
    .expired_o (expired)
  );

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned and infers a latch.
  always_comb begin
    state_d   = state_q;
    grant     = 1'b0;
    dm_win    = 1'b0;
    done      = 1'b0;
    timed_out = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (if_req_i || dm_req_i) begin
          grant   = 1'b1;
          // DM has priority except right after its own grant, so neither side starves.
          dm_win  = dm_req_i && (!if_req_i || (last_gnt_q != GNT_DM));
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (mem_ack_i) begin
          done    = 1'b1;
          state_d = ST_RESP;
        end else if (expired) begin
          done      = 1'b1;
          timed_out = 1'b1;
          state_d   = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      owner_q     <= GNT_IF;
      last_gnt_q  <= GNT_IF;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      resp_q      <= '0;
      if_hold_q   <= '0;
      dm_hold_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        owner_q     <= dm_win ? GNT_DM : GNT_IF;
        last_gnt_q  <= dm_win ? GNT_DM : GNT_IF;
        mem_req_q   <= 1'b1;
        mem_we_q    <= dm_win && dm_we_i;
        mem_addr_q  <= dm_win ? dm_addr_i : if_addr_i;
        mem_wdata_q <= dm_win ? dm_wdata_i : '0;
      end
      if (done) begin
        mem_req_q <= 1'b0;
        resp_q    <= timed_out ? ERR_DATA : (mem_we_q ? '0 : mem_rdata_i);
      end
      if (timed_out) err_q <= 1'b1;
      if (if_ready_o) if_hold_q <= resp_q;
      if (dm_ready_o) dm_hold_q <= resp_q;
    end
  end

  // A fetch withdrawn by the time of RESP is a flush: no pulse, data dropped.
  assign if_ready_o  = (state_q == ST_RESP) && (owner_q == GNT_IF) && if_req_i;
  assign dm_ready_o  = (state_q == ST_RESP) && (owner_q == GNT_DM);
  assign if_rdata_o  = if_ready_o ? resp_q : if_hold_q;
  assign dm_rdata_o  = dm_ready_o ? resp_q : dm_hold_q;

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign err_o       = err_q;
  assign stall_o     = !rst_i && ((if_req_i && !if_ready_o) || (dm_req_i && !dm_ready_o));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a per-cycle vector table for basic
// fetch and contention, then hand sequences for wait, timeout, flush and reset.
module tb_mem_port_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_rdata_o;
  logic        if_ready_o;
  logic        dm_req_i;
  logic        dm_we_i;
  logic [31:0] dm_addr_i;
  logic [31:0] dm_wdata_i;
  logic [31:0] dm_rdata_o;
  logic        dm_ready_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ack_i;
  logic        stall_o;
  logic        err_o;

  int n_checks = 0;
  int n_errors = 0;

  mem_port_arbiter #(.TIMEOUT(8)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .if_req_i    (if_req_i),
    .if_addr_i   (if_addr_i),
    .if_rdata_o  (if_rdata_o),
    .if_ready_o  (if_ready_o),
    .dm_req_i    (dm_req_i),
    .dm_we_i     (dm_we_i),
    .dm_addr_i   (dm_addr_i),
    .dm_wdata_i  (dm_wdata_i),
    .dm_rdata_o  (dm_rdata_o),
    .dm_ready_o  (dm_ready_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i),
    .mem_ack_i   (mem_ack_i),
    .stall_o     (stall_o),
    .err_o       (err_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    string       name;
    logic        if_req;
    logic [31:0] if_addr;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        ack;
    logic [31:0] rdata;
    logic        e_mem_req;
    logic        e_we;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic        e_if_ready;
    logic [31:0] e_if_rdata;
    logic        e_dm_ready;
    logic [31:0] e_dm_rdata;
    logic        e_stall;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    if_req_i    = 1'b0;
    if_addr_i   = '0;
    dm_req_i    = 1'b0;
    dm_we_i     = 1'b0;
    dm_addr_i   = '0;
    dm_wdata_i  = '0;
    mem_ack_i   = 1'b0;
    mem_rdata_i = '0;
  endtask

  initial begin
    int pulses;

    vecs[0]  = '{"t1_c0", 1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0,  1'b0, 32'h0,
                 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1};
    vecs[1]  = '{"t1_c1", 1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0,  1'b1, 32'h2001_0005,
                 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1};
    vecs[2]  = '{"t1_c2", 1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0,  1'b0, 32'h0,
                 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h2001_0005, 1'b0, 32'h0, 1'b0};
    vecs[3]  = '{"t1_c3", 1'b0, 32'h0,  1'b0, 1'b0, 32'h0, 32'h0,  1'b0, 32'h0,
                 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h2001_0005, 1'b0, 32'h0, 1'b0};
    vecs[4]  = '{"t2_c0", 1'b1, 32'h14, 1'b1, 1'b1, 32'h20, 32'hAA, 1'b0, 32'h0,
                 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h2001_0005, 1'b0, 32'h0, 1'b1};
    vecs[5]  = '{"t2_c1", 1'b1, 32'h14, 1'b1, 1'b1, 32'h20, 32'hAA, 1'b1, 32'h1234_5678,
                 1'b1, 1'b1, 32'h20, 32'hAA, 1'b0, 32'h2001_0005, 1'b0, 32'h0, 1'b1};
    vecs[6]  = '{"t2_c2", 1'b1, 32'h14, 1'b1, 1'b1, 32'h20, 32'hAA, 1'b0, 32'h0,
                 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h2001_0005, 1'b1, 32'h0, 1'b1};
    vecs[7]  = '{"t2_c3", 1'b1, 32'h14, 1'b1, 1'b0, 32'h24, 32'h0,  1'b0, 32'h0,
                 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h2001_0005, 1'b0, 32'h0, 1'b1};
    vecs[8]  = '{"t2_c4", 1'b1, 32'h14, 1'b1, 1'b0, 32'h24, 32'h0,  1'b1, 32'h0000_1111,
                 1'b1, 1'b0, 32'h14, 32'h0, 1'b0, 32'h2001_0005, 1'b0, 32'h0, 1'b1};
    vecs[9]  = '{"t2_c5", 1'b1, 32'h14, 1'b1, 1'b0, 32'h24, 32'h0,  1'b0, 32'h0,
                 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0000_1111, 1'b0, 32'h0, 1'b1};
    vecs[10] = '{"t2_c6", 1'b0, 32'h0,  1'b1, 1'b0, 32'h24, 32'h0,  1'b0, 32'h0,
                 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0000_1111, 1'b0, 32'h0, 1'b1};
    vecs[11] = '{"t2_c7", 1'b0, 32'h0,  1'b1, 1'b0, 32'h24, 32'h0,  1'b1, 32'hCAFE_0001,
                 1'b1, 1'b0, 32'h24, 32'h0, 1'b0, 32'h0000_1111, 1'b0, 32'h0, 1'b1};
    vecs[12] = '{"t2_c8", 1'b0, 32'h0,  1'b1, 1'b0, 32'h24, 32'h0,  1'b0, 32'h0,
                 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0000_1111, 1'b1, 32'hCAFE_0001, 1'b0};
    vecs[13] = '{"t2_c9", 1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  32'h0,  1'b0, 32'h0,
                 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0000_1111, 1'b0, 32'hCAFE_0001, 1'b0};

    // Reset state
    rst_i = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_mem_req", 32'(mem_req_o), 32'd0);
    check("rst_stall", 32'(stall_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_if_ready", 32'(if_ready_o), 32'd0);
    check("rst_dm_ready", 32'(dm_ready_o), 32'd0);
    check("rst_if_rdata", if_rdata_o, 32'd0);
    check("rst_dm_rdata", dm_rdata_o, 32'd0);
    next_cycle();
    rst_i = 1'b0;

    // Vector table: lone fetch, then contention DM -> IF -> DM
    for (int i = 0; i < 14; i++) begin
      if_req_i    = vecs[i].if_req;
      if_addr_i   = vecs[i].if_addr;
      dm_req_i    = vecs[i].dm_req;
      dm_we_i     = vecs[i].dm_we;
      dm_addr_i   = vecs[i].dm_addr;
      dm_wdata_i  = vecs[i].dm_wdata;
      mem_ack_i   = vecs[i].ack;
      mem_rdata_i = vecs[i].rdata;
      @(negedge clk_i);
      check({vecs[i].name, "_mem_req"}, 32'(mem_req_o), 32'(vecs[i].e_mem_req));
      if (vecs[i].e_mem_req) begin
        check({vecs[i].name, "_mem_we"}, 32'(mem_we_o), 32'(vecs[i].e_we));
        check({vecs[i].name, "_mem_addr"}, mem_addr_o, vecs[i].e_addr);
        check({vecs[i].name, "_mem_wdata"}, mem_wdata_o, vecs[i].e_wdata);
      end
      check({vecs[i].name, "_if_ready"}, 32'(if_ready_o), 32'(vecs[i].e_if_ready));
      check({vecs[i].name, "_if_rdata"}, if_rdata_o, vecs[i].e_if_rdata);
      check({vecs[i].name, "_dm_ready"}, 32'(dm_ready_o), 32'(vecs[i].e_dm_ready));
      check({vecs[i].name, "_dm_rdata"}, dm_rdata_o, vecs[i].e_dm_rdata);
      check({vecs[i].name, "_stall"}, 32'(stall_o), 32'(vecs[i].e_stall));
      next_cycle();
    end
    idle_inputs();

    // Delayed ack: five waiting cycles, ack on the sixth ISSUE cycle
    pulses = 0;
    dm_req_i  = 1'b1;
    dm_addr_i = 32'h30;
    @(negedge clk_i);
    check("dly_c0_stall", 32'(stall_o), 32'd1);
    next_cycle();
    for (int c = 1; c <= 9; c++) begin
      if (c == 6) begin
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'h55AA_55AA;
      end
      @(negedge clk_i);
      pulses += int'(dm_ready_o);
      if (c <= 6) begin
        check("dly_mem_req", 32'(mem_req_o), 32'd1);
        check("dly_mem_addr", mem_addr_o, 32'h30);
        check("dly_mem_we", 32'(mem_we_o), 32'd0);
        check("dly_stall", 32'(stall_o), 32'd1);
      end
      if (c == 7) begin
        check("dly_ready", 32'(dm_ready_o), 32'd1);
        check("dly_rdata", dm_rdata_o, 32'h55AA_55AA);
      end
      next_cycle();
      mem_ack_i   = 1'b0;
      mem_rdata_i = '0;
      if (c == 7) dm_req_i = 1'b0;
    end
    check("dly_pulses", 32'(pulses), 32'd1);

    // Timeout: no ack for 8 ISSUE cycles
    dm_req_i  = 1'b1;
    dm_addr_i = 32'h34;
    next_cycle();
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk_i);
      check("to_mem_req", 32'(mem_req_o), 32'd1);
      check("to_err_early", 32'(err_o), 32'd0);
      check("to_no_ready", 32'(dm_ready_o), 32'd0);
      next_cycle();
    end
    @(negedge clk_i);
    check("to_mem_req_drop", 32'(mem_req_o), 32'd0);
    check("to_ready", 32'(dm_ready_o), 32'd1);
    check("to_rdata", dm_rdata_o, 32'hDEAD_BEEF);
    check("to_err", 32'(err_o), 32'd1);
    next_cycle();
    dm_req_i = 1'b0;
    @(negedge clk_i);
    check("to_err_sticky", 32'(err_o), 32'd1);
    check("to_ready_once", 32'(dm_ready_o), 32'd0);
    check("to_rdata_hold", dm_rdata_o, 32'hDEAD_BEEF);
    next_cycle();

    // Fetch flush: request withdrawn during ISSUE
    pulses    = 0;
    if_req_i  = 1'b1;
    if_addr_i = 32'h38;
    next_cycle();
    @(negedge clk_i);
    check("fl_mem_addr", mem_addr_o, 32'h38);
    check("fl_mem_req", 32'(mem_req_o), 32'd1);
    pulses += int'(if_ready_o);
    next_cycle();
    if_req_i    = 1'b0;
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'h77;
    @(negedge clk_i);
    check("fl_stall", 32'(stall_o), 32'd0);
    pulses += int'(if_ready_o);
    next_cycle();
    mem_ack_i = 1'b0;
    @(negedge clk_i);
    pulses += int'(if_ready_o);
    check("fl_mem_req_drop", 32'(mem_req_o), 32'd0);
    check("fl_rdata_hold", if_rdata_o, 32'h0000_1111);
    check("fl_no_pulse", 32'(pulses), 32'd0);
    next_cycle();
    if_req_i  = 1'b1;
    if_addr_i = 32'h40;
    @(negedge clk_i);
    check("fl2_c0_mem_req", 32'(mem_req_o), 32'd0);
    next_cycle();
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'h88;
    @(negedge clk_i);
    check("fl2_mem_addr", mem_addr_o, 32'h40);
    next_cycle();
    mem_ack_i = 1'b0;
    @(negedge clk_i);
    check("fl2_ready", 32'(if_ready_o), 32'd1);
    check("fl2_rdata", if_rdata_o, 32'h88);
    check("fl2_err_sticky", 32'(err_o), 32'd1);
    next_cycle();
    if_req_i = 1'b0;

    // Asynchronous reset in the middle of ISSUE
    dm_req_i   = 1'b1;
    dm_we_i    = 1'b1;
    dm_addr_i  = 32'h50;
    dm_wdata_i = 32'h5;
    next_cycle();
    @(negedge clk_i);
    check("ar_mem_req_pre", 32'(mem_req_o), 32'd1);
    #2;
    rst_i = 1'b1;
    #1;
    check("ar_mem_req", 32'(mem_req_o), 32'd0);
    check("ar_stall", 32'(stall_o), 32'd0);
    check("ar_err", 32'(err_o), 32'd0);
    check("ar_dm_ready", 32'(dm_ready_o), 32'd0);
    check("ar_if_ready", 32'(if_ready_o), 32'd0);
    check("ar_dm_rdata", dm_rdata_o, 32'd0);
    idle_inputs();
    next_cycle();
    rst_i     = 1'b0;
    if_req_i  = 1'b1;
    if_addr_i = 32'h60;
    @(negedge clk_i);
    check("ar2_c0_mem_req", 32'(mem_req_o), 32'd0);
    next_cycle();
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'h99;
    @(negedge clk_i);
    check("ar2_c1_mem_req", 32'(mem_req_o), 32'd1);
    check("ar2_c1_addr", mem_addr_o, 32'h60);
    check("ar2_c1_we", 32'(mem_we_o), 32'd0);
    next_cycle();
    mem_ack_i = 1'b0;
    @(negedge clk_i);
    check("ar2_c2_ready", 32'(if_ready_o), 32'd1);
    check("ar2_c2_rdata", if_rdata_o, 32'h99);
    next_cycle();
    if_req_i = 1'b0;
    @(negedge clk_i);
    check("ar2_c3_ready", 32'(if_ready_o), 32'd0);
    check("ar2_c3_mem_req", 32'(mem_req_o), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
